// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader for the 8192x24 instruction
// memory. Frame layout: 0xA5, ADDR_H, ADDR_L, CNT_H, CNT_L, 3*N data bytes
// (big-endian words), CSUM. The 8-bit sum of every byte after the sync byte,
// including CSUM, must be zero. The CPU is held in reset while a frame is in
// flight and until a frame completes with a good checksum.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_rx_data, i_rx_valid    incoming byte stream
//   o_rx_ready               registered; 1 from the first cycle after reset
//   o_imem_addr/data/we      single-cycle write port into instruction memory
//   o_cpu_hold               holds the CPU in reset
//   o_busy                   frame in progress
//   o_done, o_err            one-cycle frame result pulses
module imem_loader #(
    parameter int TIMEOUT       = 1000000,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [12:0] o_imem_addr,
    output logic [23:0] o_imem_data,
    output logic        o_imem_we,
    output logic        o_cpu_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_SYNC,
        S_AH,
        S_AL,
        S_CH,
        S_CL,
        S_DATA,
        S_CSUM
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    csum;
    logic [15:0]   cnt;
    logic [1:0]    phase;
    logic [15:0]   word_buf;
    logic [IW-1:0] idle;

    logic          accept;
    logic [7:0]    csum_sum;
    logic          idle_expired;

    assign accept   = i_rx_valid & o_rx_ready;
    assign csum_sum = csum + i_rx_data;
    assign o_busy   = (state != S_SYNC);

    // An accepted byte in the same cycle always wins over the timeout.
    assign idle_expired = (state != S_SYNC) && !accept && (idle == IW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (idle_expired) begin
            state_next = S_SYNC;
        end else if (accept) begin
            case (state)
                S_SYNC: if (i_rx_data == 8'hA5) state_next = S_AH;
                S_AH:   state_next = S_AL;
                S_AL:   state_next = S_CH;
                S_CH:   state_next = S_CL;
                S_CL:   state_next = ({cnt[15:8], i_rx_data} != 16'd0) ? S_DATA : S_CSUM;
                // cnt still holds the words remaining including this one
                S_DATA: if (phase == 2'd2 && cnt == 16'd1) state_next = S_CSUM;
                S_CSUM: state_next = S_SYNC;
                default: state_next = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rx_ready  <= 1'b0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= 13'd0;
            o_imem_data <= 24'd0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_cpu_hold  <= HOLD_AT_RESET;
            csum        <= 8'd0;
            cnt         <= 16'd0;
            phase       <= 2'd0;
            word_buf    <= 16'd0;
            idle        <= '0;
        end else begin
            o_rx_ready <= 1'b1;
            o_imem_we  <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;

            // Address advances on the write cycle itself, so the write sees
            // the address the word belongs to. The next frame's address
            // bytes can never coincide with a write cycle.
            if (o_imem_we) begin
                o_imem_addr <= o_imem_addr + 13'd1;
            end

            if (state == S_SYNC || accept) begin
                idle <= '0;
            end else begin
                idle <= idle + IW'(1);
            end

            if (idle_expired) begin
                o_err <= 1'b1;
            end

            if (accept) begin
                csum <= csum_sum;
                case (state)
                    S_SYNC: begin
                        csum <= 8'd0;
                        if (i_rx_data == 8'hA5) begin
                            o_cpu_hold <= 1'b1;
                        end
                    end
                    S_AH: o_imem_addr[12:8] <= i_rx_data[4:0];
                    S_AL: o_imem_addr[7:0]  <= i_rx_data;
                    S_CH: cnt[15:8] <= i_rx_data;
                    S_CL: begin
                        cnt[7:0] <= i_rx_data;
                        phase    <= 2'd0;
                    end
                    S_DATA: begin
                        case (phase)
                            2'd0: begin
                                word_buf[15:8] <= i_rx_data;
                                phase          <= 2'd1;
                            end
                            2'd1: begin
                                word_buf[7:0] <= i_rx_data;
                                phase         <= 2'd2;
                            end
                            default: begin
                                o_imem_data <= {word_buf, i_rx_data};
                                o_imem_we   <= 1'b1;
                                cnt         <= cnt - 16'd1;
                                phase       <= 2'd0;
                            end
                        endcase
                    end
                    S_CSUM: begin
                        if (csum_sum == 8'd0) begin
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with TIMEOUT=16.
module tb_imem_loader;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [12:0] o_imem_addr;
    logic [23:0] o_imem_data;
    logic        o_imem_we;
    logic        o_cpu_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    imem_loader #(.TIMEOUT(16), .HOLD_AT_RESET(1'b1)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_ready  (o_rx_ready),
        .o_imem_addr (o_imem_addr),
        .o_imem_data (o_imem_data),
        .o_imem_we   (o_imem_we),
        .o_cpu_hold  (o_cpu_hold),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Write / pulse log, sampled mid-cycle.
    logic [12:0] wr_addr [0:63];
    logic [23:0] wr_data [0:63];
    int wr_n     = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge i_clk) begin
        if (o_imem_we === 1'b1 && wr_n < 64) begin
            wr_addr[wr_n] = o_imem_addr;
            wr_data[wr_n] = o_imem_data;
            wr_n = wr_n + 1;
        end
        if (o_done === 1'b1) done_cnt = done_cnt + 1;
        if (o_err === 1'b1) err_cnt = err_cnt + 1;
        if (o_done === 1'b1 && o_err === 1'b1) both_cnt = both_cnt + 1;
    end

    logic [7:0] frm [$];

    // Present one byte; it is accepted on the next rising edge. Returns 1 time
    // unit after that edge with valid still high so bytes stay back-to-back.
    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_frm();
        foreach (frm[i]) send_byte(frm[i]);
        i_rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge i_clk);
        total++;
        if ({o_rx_ready, o_imem_we, o_busy, o_done, o_err, o_cpu_hold} !== 6'b000001) begin
            bad++;
            $display("FAIL %s_ctrl got ready/we/busy/done/err/hold=%b want 000001", tag,
                     {o_rx_ready, o_imem_we, o_busy, o_done, o_err, o_cpu_hold});
        end
        total++;
        if (o_imem_addr !== 13'd0 || o_imem_data !== 24'd0) begin
            bad++;
            $display("FAIL %s_bus got addr=%0h data=%0h want 0 0", tag, o_imem_addr, o_imem_data);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data = 8'h00;
        repeat (3) @(posedge i_clk);
        check_reset_values("reset");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        total++;
        if (o_rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", o_rx_ready);
        end
    endtask

    task automatic test_good_frame();
        int w0;
        int d0;
        w0 = wr_n;
        d0 = done_cnt;
        frm = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34};
        foreach (frm[i]) send_byte(frm[i]);
        send_byte(8'h56);
        // write strobe in the cycle after the third byte of the word
        @(negedge i_clk);
        total++;
        if (o_imem_we !== 1'b1 || o_imem_addr !== 13'h0010 || o_imem_data !== 24'h123456) begin
            bad++;
            $display("FAIL good_wr0_timing got we=%b addr=%0h data=%0h want 1 10 123456",
                     o_imem_we, o_imem_addr, o_imem_data);
        end
        total++;
        if (o_cpu_hold !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL good_inflight got hold=%b busy=%b want 1 1", o_cpu_hold, o_busy);
        end
        frm = '{8'hAB, 8'hCD, 8'hEF, 8'hEB};
        send_frm();
        @(negedge i_clk);
        total++;
        if (o_done !== 1'b1 || o_err !== 1'b0 || o_cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL good_result got done=%b err=%b hold=%b want 1 0 0", o_done, o_err, o_cpu_hold);
        end
        idle_cycles(3);
        total++;
        if (wr_n - w0 != 2 || wr_addr[w0+1] !== 13'h0011 || wr_data[w0+1] !== 24'hABCDEF) begin
            bad++;
            $display("FAIL good_writes got n=%0d addr1=%0h data1=%0h want 2 11 abcdef",
                     wr_n - w0, wr_addr[w0+1], wr_data[w0+1]);
        end
        total++;
        if (done_cnt - d0 != 1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL good_done_once got done_pulses=%0d busy=%b want 1 0", done_cnt - d0, o_busy);
        end
    endtask

    task automatic test_bad_csum();
        int w0;
        int d0;
        int e0;
        w0 = wr_n;
        d0 = done_cnt;
        e0 = err_cnt;
        frm = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
                8'hAB, 8'hCD, 8'hEF, 8'hEC};
        send_frm();
        @(negedge i_clk);
        total++;
        if (o_err !== 1'b1 || o_done !== 1'b0 || o_cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL badcs_result got err=%b done=%b hold=%b want 1 0 1", o_err, o_done, o_cpu_hold);
        end
        idle_cycles(3);
        total++;
        if (wr_n - w0 != 2 || wr_data[w0] !== 24'h123456 || wr_data[w0+1] !== 24'hABCDEF) begin
            bad++;
            $display("FAIL badcs_writes got n=%0d d0=%0h d1=%0h want 2 123456 abcdef",
                     wr_n - w0, wr_data[w0], wr_data[w0+1]);
        end
        total++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 1 || o_cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL badcs_pulses got done=%0d err=%0d hold=%b want 0 1 1",
                     done_cnt - d0, err_cnt - e0, o_cpu_hold);
        end
    endtask

    task automatic test_wrap();
        int w0;
        int d0;
        w0 = wr_n;
        d0 = done_cnt;
        // ADDR_H=FF: top three bits dropped, start address 0x1FFF.
        // Byte sum after sync: FF+FF+00+02+33+66 = 0x99, so CSUM=0x67.
        frm = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h11,
                8'h22, 8'h22, 8'h22, 8'h67};
        send_frm();
        idle_cycles(3);
        total++;
        if (wr_n - w0 != 2 || wr_addr[w0] !== 13'h1FFF || wr_data[w0] !== 24'h111111) begin
            bad++;
            $display("FAIL wrap_wr0 got n=%0d addr=%0h data=%0h want 2 1fff 111111",
                     wr_n - w0, wr_addr[w0], wr_data[w0]);
        end
        total++;
        if (wr_addr[w0+1] !== 13'h0000 || wr_data[w0+1] !== 24'h222222) begin
            bad++;
            $display("FAIL wrap_wr1 got addr=%0h data=%0h want 0 222222", wr_addr[w0+1], wr_data[w0+1]);
        end
        total++;
        if (done_cnt - d0 != 1 || o_cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL wrap_done got done=%0d hold=%b want 1 0", done_cnt - d0, o_cpu_hold);
        end
    endtask

    task automatic test_empty_noise();
        int w0;
        int d0;
        int e0;
        w0 = wr_n;
        d0 = done_cnt;
        e0 = err_cnt;
        frm = '{8'h00, 8'h3C};
        send_frm();
        @(negedge i_clk);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL noise_busy got=%b want=0", o_busy);
        end
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frm();
        @(negedge i_clk);
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_done got done=%b busy=%b want 1 0", o_done, o_busy);
        end
        idle_cycles(3);
        total++;
        if (wr_n - w0 != 0 || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            bad++;
            $display("FAIL empty_counts got writes=%0d done=%0d err=%0d want 0 1 0",
                     wr_n - w0, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        int early;
        frm = '{8'hA5, 8'h00, 8'h10};
        send_frm();
        early = 0;
        // 0x10 accepted on the edge just passed; err must appear after the 16th edge.
        for (int k = 1; k <= 15; k++) begin
            @(posedge i_clk);
            #1;
            if (o_err === 1'b1 || o_busy !== 1'b1) early = k;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL timeout_early got err/idle break at cycle=%0d want none before 16", early);
        end
        @(posedge i_clk);
        #1;
        total++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire got err=%b busy=%b hold=%b want 1 0 1", o_err, o_busy, o_cpu_hold);
        end
        @(posedge i_clk);
        #1;
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse_width got err=%b want 0", o_err);
        end
    endtask

    task automatic test_reset_mid_data();
        frm = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frm();
        i_rst = 1'b1;
        @(posedge i_clk);
        check_reset_values("midrst");
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        test_good_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_wrap();
        test_empty_noise();
        test_timeout();
        test_reset_mid_data();
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL done_err_overlap got=%0d want=0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
